key_event_tracker: RTL and testbench

KEY_EVENT_TRACKER -- requirements
Module: key_event_tracker

---
 rtl/key_event_tracker.sv | 121 ++++++++++++
 tb/tb_key_event_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_event_tracker.sv
// Tracks PS/2 set-2 scan codes: decodes E0/F0 prefixes, keeps the held key,
// counts new presses and maps number-row keys to ASCII.
module key_event_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             press_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic [7:0]       ascii
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_down_q, key_down_d;
  logic             press_pulse_q, press_pulse_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

  logic is_nonkey;
  logic term_ext;
  logic term_break;
  logic held_match;

  // State register with synchronous active-low reset taking priority over input
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_down_q    <= 1'b0;
      press_pulse_q <= 1'b0;
      press_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_down_q    <= key_down_d;
      press_pulse_q <= press_pulse_d;
      press_cnt_q   <= press_cnt_d;
    end
  end

  // Prefix decoding and make/break handling for each strobed byte
  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_down_d    = key_down_q;
    press_pulse_d = 1'b0;
    press_cnt_d   = press_cnt_q;

    is_nonkey  = (in_data == 8'hAA) || (in_data == 8'hFA) || (in_data == 8'hEE) ||
                 (in_data == 8'hFE) || (in_data == 8'h00) || (in_data == 8'hFF);
    term_ext   = (state_q == ST_E0) || (state_q == ST_E0F0);
    term_break = (state_q == ST_F0) || (state_q == ST_E0F0);
    held_match = key_down_q && (key_code_q == in_data) && (key_ext_q == term_ext);

    if (in_valid) begin
      // E0 only acts as a prefix before any F0; after F0 it is a terminal byte
      if ((in_data == 8'hE0) && !term_break) begin
        state_d = ST_E0;
      end else if (in_data == 8'hF0) begin
        if (state_q == ST_IDLE)    state_d = ST_F0;
        else if (state_q == ST_E0) state_d = ST_E0F0;
      end else begin
        state_d = ST_IDLE;
        if (!is_nonkey) begin
          if (term_break) begin
            if (held_match) key_down_d = 1'b0;
          end else if (!held_match) begin
            key_code_d    = in_data;
            key_ext_d     = term_ext;
            key_down_d    = 1'b1;
            press_pulse_d = 1'b1;
            press_cnt_d   = press_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Number-row make codes to ASCII; extended keys never map
  always_comb begin
    ascii = 8'hFF;
    if (!key_ext_q) begin
      case (key_code_q)
        8'h16:   ascii = 8'h31;
        8'h1E:   ascii = 8'h32;
        8'h26:   ascii = 8'h33;
        8'h25:   ascii = 8'h34;
        8'h2E:   ascii = 8'h35;
        8'h36:   ascii = 8'h36;
        8'h3D:   ascii = 8'h37;
        8'h3E:   ascii = 8'h38;
        8'h46:   ascii = 8'h39;
        8'h45:   ascii = 8'h30;
        default: ascii = 8'hFF;
      endcase
    end
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_down    = key_down_q;
  assign press_pulse = press_pulse_q;
  assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_event_tracker.sv
// Scoreboard bench for key_event_tracker: a prefix-flag reference model pushes
// the expected outputs for every cycle; a monitor pops and compares them.
module tb_key_event_tracker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_down;
  logic        press_pulse;
  logic [15:0] press_cnt;
  logic [7:0]  ascii;

  typedef struct packed {
    logic [7:0]  code;
    logic        ext;
    logic        down;
    logic        pulse;
    logic [15:0] cnt;
    logic [7:0]  asc;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: prefix flags plus the held key
  bit       m_ext_pfx, m_brk_pfx;
  bit [7:0] m_code;
  bit       m_kext, m_down, m_pulse;
  int       m_cnt;

  key_event_tracker #(.CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .key_code(key_code), .key_ext(key_ext), .key_down(key_down),
    .press_pulse(press_pulse), .press_cnt(press_cnt), .ascii(ascii)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] ref_ascii(input bit [7:0] code, input bit ext);
    bit [7:0] keys [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                            8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    if (ext) return 8'hFF;
    for (int i = 0; i < 10; i++)
      if (keys[i] == code) return (i == 9) ? 8'h30 : 8'(8'h31 + i);
    return 8'hFF;
  endfunction

  task automatic model_apply(input bit rst_n, input bit v, input bit [7:0] b);
    bit brk, ext, same;
    m_pulse = 0;
    if (!rst_n) begin
      m_ext_pfx = 0; m_brk_pfx = 0; m_code = 0; m_kext = 0; m_down = 0; m_cnt = 0;
      return;
    end
    if (!v) return;
    if (b == 8'hE0 && !m_brk_pfx) begin
      m_ext_pfx = 1;
    end else if (b == 8'hF0) begin
      m_brk_pfx = 1;
    end else begin
      brk = m_brk_pfx;
      ext = m_ext_pfx;
      m_ext_pfx = 0;
      m_brk_pfx = 0;
      if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) return;
      same = m_down && m_code == b && m_kext == ext;
      if (brk) begin
        if (same) m_down = 0;
      end else if (!same) begin
        m_code = b; m_kext = ext; m_down = 1; m_pulse = 1;
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
  endtask

  // Drive one cycle of input and queue the outputs expected after the edge
  task automatic step(input bit rst_n, input bit v, input bit [7:0] b);
    obs_t e;
    @(negedge clk);
    resetn   = rst_n;
    in_valid = v;
    in_data  = b;
    model_apply(rst_n, v, b);
    e.code  = m_code;
    e.ext   = m_kext;
    e.down  = m_down;
    e.pulse = m_pulse;
    e.cnt   = 16'(m_cnt);
    e.asc   = ref_ascii(m_code, m_kext);
    exp_q.push_back(e);
  endtask

  task automatic send(input bit [7:0] b);
    step(1'b1, 1'b1, b);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set after the edge
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{key_code, key_ext, key_down, press_pulse, press_cnt, ascii};
      n_vec++;
      if (a !== e) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL outputs vec=%0d code/ext/down/pulse/cnt/ascii got %h/%b/%b/%b/%h/%h want %h/%b/%b/%b/%h/%h",
                   n_vec, a.code, a.ext, a.down, a.pulse, a.cnt, a.asc,
                   e.code, e.ext, e.down, e.pulse, e.cnt, e.asc);
      end
    end
  end

  function automatic bit [7:0] rand_byte();
    case ($urandom_range(0, 11))
      0:       return 8'hE0;
      1:       return 8'hF0;
      2:       return 8'h16;
      3:       return 8'h1E;
      4:       return 8'h75;
      5:       return 8'h26;
      6:       return 8'h45;
      7:       return 8'hAA;
      8:       return 8'hFA;
      9:       return ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
      10:      return ($urandom_range(0, 1) != 0) ? 8'hEE : 8'hFE;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h16);
    step(1'b1, 1'b0, 8'h00);

    // Basic press/release, then typematic repeat
    send(8'h16); send(8'hF0); send(8'h16); step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    send(8'h1E); send(8'h1E); send(8'h1E); send(8'hF0); send(8'h1E);
    step(1'b0, 1'b0, 8'h00);
    // Extended key, then same code unextended
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h75);
    step(1'b0, 1'b0, 8'h00);
    // Rollover: stale break ignored, matching break releases
    send(8'h16); send(8'h1E); send(8'hF0); send(8'h16); send(8'hF0); send(8'h1E);
    // Repeated prefixes and E0 after F0
    send(8'hE0); send(8'hE0); send(8'h26); send(8'hF0); send(8'hF0); send(8'hE0);
    send(8'hE0); send(8'hF0); send(8'hF0); send(8'h26);
    // Reset mid-prefix with a coincident byte
    send(8'hE0); send(8'hF0); step(1'b0, 1'b1, 8'h16); send(8'h16);
    step(1'b1, 1'b0, 8'h00);

    // Random traffic with gaps, junk while idle, and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b0, $urandom_range(0, 1) != 0, rand_byte());
      else
        step(1'b1, $urandom_range(0, 3) != 0, rand_byte());
    end

    // Counter wrap: alternate two keys so each byte is a new press
    step(1'b0, 1'b0, 8'h00);
    for (int unsigned i = 0; i < 65535; i++)
      send((i % 2 == 0) ? 8'h16 : 8'h1E);
    send(8'hAA); send(8'hFA);
    send(8'h45);
    step(1'b1, 1'b0, 8'h00);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
